wqe_fetch_responder: RTL and testbench

//  WQE store and read responder: serves the tx engine's WQE fetch requests.
//  - Host/doorbell logic writes WQE entries (data + QPN) into an internal table indexed by WQE id.
//  - The tx engine issues WQE request ids; the block returns data/qpn/id on a valid/ready stream.
//  - It is the serving end of the tx engine's wqe_req -> wqe data exchange.

---
 rtl/wqe_fetch_responder.sv | 251 +++++++++++++++++++++++++
 tb/tb_wqe_fetch_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wqe_fetch_responder.sv
// -----------------------------------------------------------------------------
// wqe_fetch_responder
//
// Purpose:
//   WQE store and read responder. The host/doorbell side writes WQE entries
//   (payload + QPN) into a table indexed by WQE id. The tx engine sends WQE ids
//   on a request stream, and this block returns the stored payload, QPN and the
//   echoed id on a response stream. If the entry is not valid, the response
//   carries err = 1 with zeroed payload and QPN.
//
//   Pipeline: request accept -> table read (1 cycle) -> 2-entry output FIFO.
//   A request accepted at edge k is presented on m_axis_* after edge k+1.
//
// Ports:
//   clk                  in   clock
//   rst                  in   synchronous active-high reset
//   s_axis_wqe_req_id    in   requested WQE id
//   s_axis_wqe_req_valid in   request valid
//   s_axis_wqe_req_ready out  request ready
//   m_axis_wqe_data      out  WQE payload (zero when err)
//   m_axis_wqe_qpn       out  QPN stored with entry (zero when err)
//   m_axis_wqe_id        out  echo of requested id
//   m_axis_wqe_err       out  1 = requested entry was not valid
//   m_axis_wqe_valid     out  response valid
//   m_axis_wqe_ready     in   response ready
//   s_wqe_wr_id          in   table write index
//   s_wqe_wr_data        in   table write payload
//   s_wqe_wr_qpn         in   table write QPN
//   s_wqe_wr_valid       in   write strobe (always accepted)
//   status_valid_count   out  number of valid table entries
// -----------------------------------------------------------------------------
module wqe_fetch_responder #(
    parameter int WQE_INDEX_WIDTH     = 10,
    parameter int AXIS_WQE_DATA_WIDTH = 256,
    parameter int QPN_WIDTH           = 24,
    parameter int CLEAR_ON_READ       = 1
) (
    input  logic                           clk,
    input  logic                           rst,

    input  logic [WQE_INDEX_WIDTH-1:0]     s_axis_wqe_req_id,
    input  logic                           s_axis_wqe_req_valid,
    output logic                           s_axis_wqe_req_ready,

    output logic [AXIS_WQE_DATA_WIDTH-1:0] m_axis_wqe_data,
    output logic [QPN_WIDTH-1:0]           m_axis_wqe_qpn,
    output logic [WQE_INDEX_WIDTH-1:0]     m_axis_wqe_id,
    output logic                           m_axis_wqe_err,
    output logic                           m_axis_wqe_valid,
    input  logic                           m_axis_wqe_ready,

    input  logic [WQE_INDEX_WIDTH-1:0]     s_wqe_wr_id,
    input  logic [AXIS_WQE_DATA_WIDTH-1:0] s_wqe_wr_data,
    input  logic [QPN_WIDTH-1:0]           s_wqe_wr_qpn,
    input  logic                           s_wqe_wr_valid,

    output logic [WQE_INDEX_WIDTH:0]       status_valid_count
);

    localparam int DEPTH   = 1 << WQE_INDEX_WIDTH;
    localparam int ENTRY_W = AXIS_WQE_DATA_WIDTH + QPN_WIDTH;
    localparam int CNT_W   = WQE_INDEX_WIDTH + 1;

    typedef struct packed {
        logic [AXIS_WQE_DATA_WIDTH-1:0] data;
        logic [QPN_WIDTH-1:0]           qpn;
        logic [WQE_INDEX_WIDTH-1:0]     id;
        logic                           err;
    } resp_t;

    // Table storage (no reset; validity is tracked by the bitmap)
    logic [ENTRY_W-1:0]     mem [DEPTH];

    // Valid bitmap and entry counter
    logic [DEPTH-1:0]       valid_q;
    logic [DEPTH-1:0]       valid_d;
    logic [DEPTH-1:0]       set_mask_s;
    logic [DEPTH-1:0]       clr_mask_s;
    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       count_d;
    logic                   inc_s;
    logic                   dec_s;

    // Read stage
    logic                   s1_valid_q;
    logic [WQE_INDEX_WIDTH-1:0] s1_id_q;
    logic                   s1_hit_q;
    logic [ENTRY_W-1:0]     ram_rd_q;

    // Output FIFO: slot0 is the head and drives the outputs directly
    resp_t                  slot0_q;
    resp_t                  slot0_d;
    resp_t                  slot1_q;
    resp_t                  slot1_d;
    resp_t                  push_entry_s;
    logic [1:0]             fifo_cnt_q;
    logic [1:0]             fifo_cnt_d;
    logic                   out_valid_q;

    // Handshake helpers
    logic                   accept_s;
    logic                   pop_s;
    logic                   push_s;
    logic                   same_id_s;
    logic                   clear_en_s;
    logic [2:0]             occupancy_s;

    assign clear_en_s = (CLEAR_ON_READ != 0);
    assign pop_s      = out_valid_q & m_axis_wqe_ready;
    assign push_s     = s1_valid_q;

    // The head slot leaving this cycle frees room, so ready looks at occupancy
    // after the pop; this is what lets one response per cycle flow through.
    assign occupancy_s = {1'b0, fifo_cnt_q} + {2'b00, s1_valid_q} - {2'b00, pop_s};
    assign s_axis_wqe_req_ready = ~rst & (occupancy_s < 3'd2);

    assign accept_s  = s_axis_wqe_req_valid & s_axis_wqe_req_ready;
    assign same_id_s = s_wqe_wr_valid & accept_s & (s_wqe_wr_id == s_axis_wqe_req_id);

    assign m_axis_wqe_data    = slot0_q.data;
    assign m_axis_wqe_qpn     = slot0_q.qpn;
    assign m_axis_wqe_id      = slot0_q.id;
    assign m_axis_wqe_err     = slot0_q.err;
    assign m_axis_wqe_valid   = out_valid_q;
    assign status_valid_count = count_q;

    // Bitmap next state: the set mask is ORed last so a same-edge write wins over a clear
    always_comb begin
        set_mask_s = s_wqe_wr_valid ? (DEPTH'(1) << s_wqe_wr_id) : {DEPTH{1'b0}};
        clr_mask_s = (accept_s & clear_en_s) ? (DEPTH'(1) << s_axis_wqe_req_id) : {DEPTH{1'b0}};
        valid_d    = (valid_q & ~clr_mask_s) | set_mask_s;
    end

    // Incremental popcount: +1 when a write makes an entry valid, -1 when a
    // request clears a valid entry that is not simultaneously rewritten
    always_comb begin
        inc_s   = s_wqe_wr_valid & ~valid_q[s_wqe_wr_id];
        dec_s   = clear_en_s & accept_s & valid_q[s_axis_wqe_req_id] & ~same_id_s;
        count_d = count_q + CNT_W'(inc_s) - CNT_W'(dec_s);
    end

    // Table write port and registered read port with same-edge write bypass
    always_ff @(posedge clk) begin
        if (s_wqe_wr_valid) begin
            mem[s_wqe_wr_id] <= {s_wqe_wr_data, s_wqe_wr_qpn};
        end
        if (same_id_s) begin
            ram_rd_q <= {s_wqe_wr_data, s_wqe_wr_qpn};
        end else begin
            ram_rd_q <= mem[s_axis_wqe_req_id];
        end
    end

    // Valid bitmap and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= {DEPTH{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    // Read-stage tracking: the hit flag is frozen at acceptance so later
    // writes cannot change what this request returns
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_id_q    <= {WQE_INDEX_WIDTH{1'b0}};
            s1_hit_q   <= 1'b0;
        end else begin
            s1_valid_q <= accept_s;
            if (accept_s) begin
                s1_id_q  <= s_axis_wqe_req_id;
                s1_hit_q <= valid_q[s_axis_wqe_req_id] | same_id_s;
            end
        end
    end

    // Build the response; invalid entries return zero payload and QPN
    always_comb begin
        push_entry_s.id  = s1_id_q;
        push_entry_s.err = ~s1_hit_q;
        if (s1_hit_q) begin
            push_entry_s.data = ram_rd_q[ENTRY_W-1:QPN_WIDTH];
            push_entry_s.qpn  = ram_rd_q[QPN_WIDTH-1:0];
        end else begin
            push_entry_s.data = {AXIS_WQE_DATA_WIDTH{1'b0}};
            push_entry_s.qpn  = {QPN_WIDTH{1'b0}};
        end
    end

    // Two-slot shift FIFO next state; slot0 always holds the oldest response
    always_comb begin
        slot0_d    = slot0_q;
        slot1_d    = slot1_q;
        fifo_cnt_d = fifo_cnt_q;
        case (fifo_cnt_q)
            2'd0: begin
                if (push_s) begin
                    slot0_d    = push_entry_s;
                    fifo_cnt_d = 2'd1;
                end else begin
                    fifo_cnt_d = 2'd0;
                end
            end
            2'd1: begin
                case ({pop_s, push_s})
                    2'b11: slot0_d = push_entry_s;
                    2'b01: begin
                        slot1_d    = push_entry_s;
                        fifo_cnt_d = 2'd2;
                    end
                    2'b10: fifo_cnt_d = 2'd0;
                    default: fifo_cnt_d = 2'd1;
                endcase
            end
            2'd2: begin
                if (pop_s) begin
                    slot0_d = slot1_q;
                    if (push_s) begin
                        slot1_d    = push_entry_s;
                        fifo_cnt_d = 2'd2;
                    end else begin
                        fifo_cnt_d = 2'd1;
                    end
                end else begin
                    fifo_cnt_d = 2'd2;
                end
            end
            default: fifo_cnt_d = 2'd0;
        endcase
    end

    // FIFO registers; reset discards everything queued or in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            slot0_q     <= '0;
            slot1_q     <= '0;
            fifo_cnt_q  <= 2'd0;
            out_valid_q <= 1'b0;
        end else begin
            slot0_q     <= slot0_d;
            slot1_q     <= slot1_d;
            fifo_cnt_q  <= fifo_cnt_d;
            out_valid_q <= (fifo_cnt_d != 2'd0);
        end
    end

endmodule

// File: tb/tb_wqe_fetch_responder.sv
module tb_wqe_fetch_responder;

    localparam int IW = 10;
    localparam int DW = 256;
    localparam int QW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] req_id;
    logic          req_valid;
    logic          req_ready;
    logic [DW-1:0] m_data;
    logic [QW-1:0] m_qpn;
    logic [IW-1:0] m_id;
    logic          m_err;
    logic          m_valid;
    logic          m_ready;
    logic [IW-1:0] wr_id;
    logic [DW-1:0] wr_data;
    logic [QW-1:0] wr_qpn;
    logic          wr_valid;
    logic [IW:0]   count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wqe_fetch_responder #(
        .WQE_INDEX_WIDTH(IW), .AXIS_WQE_DATA_WIDTH(DW), .QPN_WIDTH(QW), .CLEAR_ON_READ(1)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_wqe_req_id(req_id), .s_axis_wqe_req_valid(req_valid),
        .s_axis_wqe_req_ready(req_ready),
        .m_axis_wqe_data(m_data), .m_axis_wqe_qpn(m_qpn), .m_axis_wqe_id(m_id),
        .m_axis_wqe_err(m_err), .m_axis_wqe_valid(m_valid), .m_axis_wqe_ready(m_ready),
        .s_wqe_wr_id(wr_id), .s_wqe_wr_data(wr_data), .s_wqe_wr_qpn(wr_qpn),
        .s_wqe_wr_valid(wr_valid), .status_valid_count(count)
    );

    // WQE payload: len in [31:0], rip in [95:32], rest zero
    function automatic logic [DW-1:0] mk(input logic [31:0] len, input logic [63:0] rip);
        logic [DW-1:0] d;
        d = '0;
        d[31:0]  = len;
        d[95:32] = rip;
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int id, input int len, input logic [63:0] rip, input int qpn);
        wr_id    = IW'(id);
        wr_data  = mk(32'(len), rip);
        wr_qpn   = QW'(qpn);
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_id = '0; m_ready = 1'b1;
        wr_valid = 1'b0; wr_id = '0; wr_data = '0; wr_qpn = '0;
        repeat (3) tick();
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b want 0", req_ready); end
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", m_valid); end
        n_cmp++; if (count !== 11'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", count); end
        n_cmp++; if ({m_data, m_qpn, m_id, m_err} !== '0) begin n_err++; $display("FAIL rst_outputs not zero id %0d qpn %0d err %b", m_id, m_qpn, m_err); end
        rst = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_ready got %b want 1", req_ready); end
    endtask

    task automatic test_write_read();
        wr(6, 3072, 64'h12345678, 24);
        n_cmp++; if (count !== 11'd1) begin n_err++; $display("FAIL wr_count got %0d want 1", count); end
        req_id = 10'd6; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rd_latency valid early got %b want 0", m_valid); end
        n_cmp++; if (count !== 11'd0) begin n_err++; $display("FAIL rd_clear_count got %0d want 0", count); end
        tick();
        n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL rd_valid got %b want 1", m_valid); end
        n_cmp++; if (m_id !== 10'd6) begin n_err++; $display("FAIL rd_id got %0d want 6", m_id); end
        n_cmp++; if (m_data[31:0] !== 32'd3072) begin n_err++; $display("FAIL rd_len got %0d want 3072", m_data[31:0]); end
        n_cmp++; if (m_data !== mk(32'd3072, 64'h12345678)) begin n_err++; $display("FAIL rd_data got %h", m_data); end
        n_cmp++; if (m_qpn !== 24'd24) begin n_err++; $display("FAIL rd_qpn got %0d want 24", m_qpn); end
        n_cmp++; if (m_err !== 1'b0) begin n_err++; $display("FAIL rd_err got %b want 0", m_err); end
        tick();
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rd_pop valid got %b want 0", m_valid); end
    endtask

    task automatic test_invalid_entry();
        req_id = 10'd4; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL inv_valid got %b want 1", m_valid); end
        n_cmp++; if (m_err !== 1'b1) begin n_err++; $display("FAIL inv_err got %b want 1", m_err); end
        n_cmp++; if (m_data !== '0) begin n_err++; $display("FAIL inv_data got %h want 0", m_data); end
        n_cmp++; if (m_qpn !== 24'd0) begin n_err++; $display("FAIL inv_qpn got %0d want 0", m_qpn); end
        n_cmp++; if (m_id !== 10'd4) begin n_err++; $display("FAIL inv_id got %0d want 4", m_id); end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) wr(i, 100 + i, 64'h0, 50 + i);
        n_cmp++; if (count !== 11'd8) begin n_err++; $display("FAIL b2b_count_full got %0d want 8", count); end
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                req_id = IW'(c); req_valid = 1'b1;
                #1;
                n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready cycle %0d got %b want 1", c, req_ready); end
            end else begin
                req_valid = 1'b0;
            end
            tick();
            if (c >= 1 && c <= 8) begin
                n_cmp++;
                if (m_valid !== 1'b1 || m_id !== IW'(c - 1) || m_data !== mk(32'(100 + c - 1), 64'h0)
                    || m_qpn !== QW'(50 + c - 1) || m_err !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_resp cycle %0d got valid %b id %0d len %0d qpn %0d err %b want id %0d len %0d",
                             c, m_valid, m_id, m_data[31:0], m_qpn, m_err, c - 1, 100 + c - 1);
                end
            end
        end
        n_cmp++; if (count !== 11'd0) begin n_err++; $display("FAIL b2b_count_empty got %0d want 0", count); end
        tick();
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain valid got %b want 0", m_valid); end
    endtask

    task automatic test_stall();
        int issued;
        int got;
        for (int i = 0; i < 4; i++) wr(10 + i, 200 + i, 64'h0, 70 + i);
        m_ready = 1'b0;
        issued = 0;
        for (int c = 0; c < 12; c++) begin
            req_valid = (issued < 4); req_id = IW'(10 + issued);
            #1;
            if (req_valid && req_ready) issued++;
            tick();
            if (c >= 1) begin
                n_cmp++;
                if (m_valid !== 1'b1 || m_id !== 10'd10 || m_data !== mk(32'd200, 64'h0) || m_qpn !== 24'd70) begin
                    n_err++;
                    $display("FAIL stall_hold cycle %0d got valid %b id %0d len %0d want id 10 len 200", c, m_valid, m_id, m_data[31:0]);
                end
            end
        end
        n_cmp++; if (issued !== 2) begin n_err++; $display("FAIL stall_accepts got %0d want 2", issued); end
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready got %b want 0", req_ready); end
        m_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            req_valid = (issued < 4); req_id = IW'(10 + issued);
            #1;
            if (m_valid && m_ready) begin
                n_cmp++;
                if (m_id !== IW'(10 + got) || m_data !== mk(32'(200 + got), 64'h0) || m_err !== 1'b0) begin
                    n_err++;
                    $display("FAIL stall_order resp %0d got id %0d len %0d want id %0d len %0d", got, m_id, m_data[31:0], 10 + got, 200 + got);
                end
                got++;
            end
            if (req_valid && req_ready) issued++;
            tick();
        end
        req_valid = 1'b0;
        n_cmp++; if (got !== 4) begin n_err++; $display("FAIL stall_drain got %0d responses want 4", got); end
        n_cmp++; if (count !== 11'd0) begin n_err++; $display("FAIL stall_count got %0d want 0", count); end
    endtask

    task automatic test_same_edge_bypass();
        wr(3, 300, 64'h0, 33);
        n_cmp++; if (count !== 11'd1) begin n_err++; $display("FAIL byp_pre_count got %0d want 1", count); end
        wr_id = 10'd3; wr_data = mk(32'd4096, 64'h0); wr_qpn = 24'd77; wr_valid = 1'b1;
        req_id = 10'd3; req_valid = 1'b1;
        tick();
        wr_valid = 1'b0; req_valid = 1'b0;
        n_cmp++; if (count !== 11'd1) begin n_err++; $display("FAIL byp_count got %0d want 1", count); end
        tick();
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== mk(32'd4096, 64'h0) || m_qpn !== 24'd77 || m_err !== 1'b0 || m_id !== 10'd3) begin
            n_err++;
            $display("FAIL byp_resp got valid %b len %0d qpn %0d err %b id %0d want len 4096 qpn 77 err 0 id 3",
                     m_valid, m_data[31:0], m_qpn, m_err, m_id);
        end
        tick();
        // entry must still be valid: a second read hits and then clears it
        req_id = 10'd3; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n_cmp++; if (count !== 11'd0) begin n_err++; $display("FAIL byp_reread_count got %0d want 0", count); end
        tick();
        n_cmp++;
        if (m_valid !== 1'b1 || m_err !== 1'b0 || m_data !== mk(32'd4096, 64'h0)) begin
            n_err++;
            $display("FAIL byp_still_valid got valid %b err %b len %0d want 1 0 4096", m_valid, m_err, m_data[31:0]);
        end
        tick();
    endtask

    task automatic test_reset_mid_op();
        wr(20, 500, 64'h0, 1);
        wr(21, 501, 64'h0, 2);
        n_cmp++; if (count !== 11'd2) begin n_err++; $display("FAIL mid_pre_count got %0d want 2", count); end
        m_ready = 1'b0;
        req_id = 10'd20; req_valid = 1'b1;
        tick();
        req_id = 10'd21;
        tick();
        req_valid = 1'b0;
        tick();
        n_cmp++; if (m_valid !== 1'b1 || req_ready !== 1'b0) begin n_err++; $display("FAIL mid_queued got valid %b ready %b want 1 0", m_valid, req_ready); end
        rst = 1'b1;
        tick();
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got %b want 0", m_valid); end
        n_cmp++; if (count !== 11'd0) begin n_err++; $display("FAIL mid_rst_count got %0d want 0", count); end
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready got %b want 0", req_ready); end
        rst = 1'b0; m_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL mid_post_ready got %b want 1", req_ready); end
        req_id = 10'd20; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        n_cmp++;
        if (m_valid !== 1'b1 || m_err !== 1'b1 || m_id !== 10'd20 || m_data !== '0) begin
            n_err++;
            $display("FAIL mid_post_read got valid %b err %b id %0d len %0d want 1 1 20 0", m_valid, m_err, m_id, m_data[31:0]);
        end
        tick();
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL mid_final_valid got %b want 0", m_valid); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_invalid_entry();
        test_back_to_back();
        test_stall();
        test_same_edge_bypass();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
